// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame scheduler.
// Holds the default frame start marker, the scheduler state encoding and
// the fixed number of non-payload bytes per frame (sync, id, checksum).
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Non-payload bytes per frame: sync + source id + checksum.
  localparam int FRAME_OVERHEAD = 3;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ID,
    PAY,
    CSUM,
    DONE
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping. Ports: req_i request vector, ptr_i search start,
// gnt_o one-hot grant, gnt_id_o grant index, any_o at least one request.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_id_o,
  output logic          any_o
);

  int idx;

  always_comb begin
    idx      = 0;
    gnt_id_o = '0;
    any_o    = |req_i;
    // Scan offsets from far to near so the requester closest to the
    // pointer is the last one written and therefore wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (req_i[idx]) gnt_id_o = IW'(idx);
    end
    gnt_o = any_o ? (N'(1) << gnt_id_o) : '0;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Packet round-robin scheduler sharing one 8N1 UART transmitter between
// NUM_REQ byte sources; frames each packet as SYNC, id, payload, XOR checksum.
// Ports: clk/rst_n; req_valid/req_data/req_last in, req_ready out (per source);
// tx_data/tx_valid to the transmitter, tx_busy from it; grant_id, active status.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int          NUM_REQ   = 4,
  parameter int          MAX_LEN   = 16,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
  localparam int         IDW       = $clog2(NUM_REQ),
  localparam int         CW        = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_busy,
  output logic [IDW-1:0]         grant_id,
  output logic                   active
);

  state_e               state_q;
  logic [IDW-1:0]       rr_ptr_q;
  logic [IDW-1:0]       grant_q;
  logic [NUM_REQ-1:0]   gnt_oh_q;
  logic                 active_q;
  logic [7:0]           tx_data_q;
  logic                 tx_valid_q;
  logic                 guard_q;
  logic [7:0]           csum_q;
  logic [CW-1:0]        cnt_q;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDW-1:0]       arb_id;
  logic                 arb_any;

  logic                 slot_open;
  logic                 pay_vld;
  logic                 pay_last;
  logic [7:0]           pay_byte;
  logic [7:0]           id_byte;
  logic [IDW-1:0]       next_ptr_d;

  rr_arbiter #(.N(NUM_REQ), .IW(IDW)) u_arb (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (arb_gnt),
    .gnt_id_o (arb_id),
    .any_o    (arb_any)
  );

  // The transmitter only raises busy the cycle after it samples tx_valid;
  // guard_q blocks that one blind cycle.
  assign slot_open  = !tx_busy && !tx_valid_q && !guard_q;
  assign pay_vld    = req_valid[grant_q];
  assign pay_last   = req_last[grant_q];
  assign pay_byte   = req_data[{grant_q, 3'b000} +: 8];
  assign id_byte    = 8'(grant_q);
  assign next_ptr_d = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);

  always_comb begin
    req_ready = '0;
    if (state_q == PAY && slot_open) req_ready = req_valid & gnt_oh_q;
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign grant_id = grant_q;
  assign active   = active_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      gnt_oh_q   <= '0;
      active_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      guard_q    <= 1'b0;
      csum_q     <= '0;
      cnt_q      <= '0;
    end else begin
      tx_valid_q <= 1'b0;
      guard_q    <= tx_valid_q;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (arb_any) begin
            grant_q  <= arb_id;
            gnt_oh_q <= arb_gnt;
            active_q <= 1'b1;
            state_q  <= HDR;
          end
        end
        HDR: if (slot_open) begin
          tx_data_q  <= SYNC_BYTE;
          tx_valid_q <= 1'b1;
          state_q    <= ID;
        end
        ID: if (slot_open) begin
          tx_data_q  <= id_byte;
          tx_valid_q <= 1'b1;
          csum_q     <= id_byte;
          cnt_q      <= '0;
          state_q    <= PAY;
        end
        PAY: if (slot_open && pay_vld) begin
          tx_data_q  <= pay_byte;
          tx_valid_q <= 1'b1;
          csum_q     <= csum_q ^ pay_byte;
          cnt_q      <= cnt_q + CW'(1);
          // Hitting MAX_LEN closes the frame even without last; the rest
          // of the packet goes out in a later frame.
          if (pay_last || cnt_q == CW'(MAX_LEN - 1)) state_q <= CSUM;
        end
        CSUM: if (slot_open) begin
          tx_data_q  <= csum_q;
          tx_valid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: if (slot_open) begin
          active_q <= 1'b0;
          rr_ptr_q <= next_ptr_d;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a busy-pacing transmitter model,
// per-source packet queues and a scoreboard of expected line bytes.
module tb_uart_tx_scheduler;

  localparam int N        = 4;
  localparam int ML       = 16;
  localparam int BUSY_CYC = 40;  // 10 bit times at 4 clocks per bit

  typedef struct packed {
    logic       is_id;
    logic [7:0] b;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           active;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NUM_REQ(N), .MAX_LEN(ML), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: busy rises the cycle after it samples tx_valid.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_valid) busy_cnt <= BUSY_CYC;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Source model: per-source queue of {last, data}; hold forces valid low.
  logic [8:0] srcq [N][$];
  logic [N-1:0] hold = '0;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!hold[i] && srcq[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = srcq[i][0][7:0];
        req_last[i]        = srcq[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (req_ready[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
  end

  // Scoreboard: every tx_valid pulse pops one expected byte.
  exp_t exp_q[$];
  exp_t e_cur;
  logic prev_vld = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid) begin
        check("tx_valid_while_busy", 32'(tx_busy), 0);
        check("tx_valid_width", 32'(prev_vld), 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL unexpected_byte: observed %0h required none", tx_data);
        end else begin
          e_cur = exp_q.pop_front();
          check("tx_byte", 32'(tx_data), 32'(e_cur.b));
          if (e_cur.is_id) check("grant_id_at_id", 32'(grant_id), 32'(e_cur.b));
        end
      end
      if (req_ready != '0) begin
        check("req_ready_onehot", 32'($onehot(req_ready)), 1);
        check("req_ready_granted", 32'(req_ready[grant_id]), 1);
        check("req_ready_active", 32'(active), 1);
      end
    end
    prev_vld = tx_valid;
  end

  logic [7:0] pl[$];

  task automatic add_pkt(input int src, input logic [7:0] p[$], input bit with_last);
    for (int k = 0; k < p.size(); k++)
      srcq[src].push_back({(with_last && k == p.size() - 1), p[k]});
  endtask

  task automatic push_frame(input logic [7:0] id, input logic [7:0] p[$]);
    logic [7:0] cs;
    cs = id;
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b1, id});
    for (int k = 0; k < p.size(); k++) begin
      exp_q.push_back({1'b0, p[k]});
      cs = cs ^ p[k];
    end
    exp_q.push_back({1'b0, cs});
  endtask

  task automatic wait_drain(input int max);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max) begin
      @(negedge clk);
      c++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_idle(input int max);
    int c;
    c = 0;
    while (active !== 1'b0 && c < max) begin
      @(negedge clk);
      c++;
    end
    check("idle_timeout", 32'(active), 0);
  endtask

  initial begin
    int c;
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_active", 32'(active), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Sources 1 and 2 together, pointer 0: source 1 first, then 2.
    pl.delete(); pl.push_back(8'h11); pl.push_back(8'h12);
    add_pkt(1, pl, 1'b1); push_frame(8'h01, pl);
    pl.delete(); pl.push_back(8'h21);
    add_pkt(2, pl, 1'b1); push_frame(8'h02, pl);
    wait_drain(2000);
    wait_idle(200);

    // Pointer now 3: source 3 beats source 0; source 0 frame is A5,00,03,03.
    pl.delete(); pl.push_back(8'h33);
    add_pkt(3, pl, 1'b1); push_frame(8'h03, pl);
    pl.delete(); pl.push_back(8'h03);
    add_pkt(0, pl, 1'b1); push_frame(8'h00, pl);
    wait_drain(2000);
    wait_idle(200);

    // Stall: source 1 withholds valid for 50 cycles after its ID byte.
    pl.delete(); pl.push_back(8'h44); pl.push_back(8'h55);
    add_pkt(1, pl, 1'b1); push_frame(8'h01, pl);
    c = 0;
    while (exp_q.size() > 3 && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("stall_id_seen", exp_q.size(), 3);
    hold[1] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("stall_tx_valid", 32'(tx_valid), 0);
      check("stall_req_ready", 32'(req_ready), 0);
    end
    hold[1] = 1'b0;
    wait_drain(1000);
    wait_idle(200);

    // Fairness: source 0 streams two packets, source 2 arrives mid-frame.
    pl.delete(); pl.push_back(8'h60); pl.push_back(8'h61);
    add_pkt(0, pl, 1'b1); push_frame(8'h00, pl);
    pl.delete(); pl.push_back(8'h62);
    add_pkt(0, pl, 1'b1);
    pl.delete(); pl.push_back(8'h70); push_frame(8'h02, pl);
    pl.delete(); pl.push_back(8'h62); push_frame(8'h00, pl);
    c = 0;
    while (!(active === 1'b1 && grant_id === 2'd0) && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("fair_src0_granted", 32'(grant_id), 0);
    pl.delete(); pl.push_back(8'h70);
    add_pkt(2, pl, 1'b1);
    wait_drain(3000);
    wait_idle(200);

    // Truncation: 20 bytes from source 3 without last.
    pl.delete();
    for (int k = 0; k < 20; k++) pl.push_back(8'(k));
    add_pkt(3, pl, 1'b0);
    pl.delete();
    for (int k = 0; k < 16; k++) pl.push_back(8'(k));
    push_frame(8'h03, pl);
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b1, 8'h03});
    for (int k = 16; k < 20; k++) exp_q.push_back({1'b0, 8'(k)});
    wait_drain(4000);
    repeat (50) @(negedge clk);
    check("trunc_active_stalled", 32'(active), 1);

    // Asynchronous reset mid-PAY.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_tx_valid", 32'(tx_valid), 0);
    check("arst_active", 32'(active), 0);
    check("arst_req_ready", 32'(req_ready), 0);
    check("arst_grant_id", 32'(grant_id), 0);
    srcq[3].delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh frame after reset starts with sync.
    pl.delete(); pl.push_back(8'h5A);
    add_pkt(2, pl, 1'b1); push_frame(8'h02, pl);
    wait_drain(2000);
    wait_idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
